// File: rtl/lafpm_pkg.sv
// -----------------------------------------------------------------------------
// lafpm_pkg
// Shared types and helpers for the serial logarithmic (Mitchell) approximate
// floating-point multiplier.
//   lafpm_state_e : beat-loader / compute / beat-sender FSM states
//   NAN/OVF/UDF   : bit positions inside the 3-bit exception flag vector
//   beats_of()    : number of bus beats needed to carry one operand
//   canon_nan()   : canonical quiet NaN pattern (sign 0, exponent all ones,
//                   mantissa MSB set), right-aligned in a 64-bit word
//   signed_inf()  : signed infinity pattern, right-aligned in a 64-bit word
// -----------------------------------------------------------------------------
package lafpm_pkg;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      SEND    = 2'd2
   } lafpm_state_e;

   localparam int NAN = 2;
   localparam int OVF = 1;
   localparam int UDF = 0;

   function automatic int beats_of(input int width, input int bus_w);
      return (width + bus_w - 1) / bus_w;
   endfunction

   function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
      logic [63:0] v;
      v = ((64'd1 << exp_w) - 64'd1) << man_w;
      v = v | (64'd1 << (man_w - 1));
      return v;
   endfunction

   function automatic logic [63:0] signed_inf(input logic sign, input int exp_w, input int man_w);
      logic [63:0] v;
      v = ((64'd1 << exp_w) - 64'd1) << man_w;
      v[exp_w + man_w] = sign;
      return v;
   endfunction

endpackage

// File: rtl/lafpm_core.sv
// -----------------------------------------------------------------------------
// lafpm_core
// Purely combinational classify + log-domain add + saturate stage.
// Treats {exponent, mantissa} as a fixed-point log2 value, so a product is
// approximated by adding the two fields and removing one bias.
//   a, b   : in  1+EXP_W+MAN_W  operands {sign, exponent, mantissa}
//   result : out 1+EXP_W+MAN_W  approximate product
//   flags  : out 3              {nan, overflow, underflow}
// Optional build macro MITCHELL_CORR_EN: adds a small constant to the log sum
// when both mantissas are nonzero, pulling the mean Mitchell error toward zero.
// -----------------------------------------------------------------------------
module lafpm_core
   import lafpm_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
)(
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic [EXP_W+MAN_W:0] result,
   output logic [2:0]           flags
);

   localparam int FW   = EXP_W + MAN_W;
   localparam int SW   = FW + 2;
   localparam int BIAS = (2 ** (EXP_W - 1)) - 1;
   localparam logic [SW-1:0]          BIAS_SH  = SW'(BIAS) << MAN_W;
   localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W+2)'((2 ** EXP_W) - 1);
   localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
   localparam logic [FW:0]             NAN_PAT  = (FW+1)'(canon_nan(EXP_W, MAN_W));

   logic                    sign_r;
   logic [EXP_W-1:0]        ea, eb;
   logic [MAN_W-1:0]        ma, mb;
   logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [SW-1:0]           sum;
   logic signed [EXP_W+1:0] sum_exp;

   assign sign_r = a[FW] ^ b[FW];
   assign ea     = a[FW-1:MAN_W];
   assign eb     = b[FW-1:MAN_W];
   assign ma     = a[MAN_W-1:0];
   assign mb     = b[MAN_W-1:0];

   // A zero exponent field means zero; subnormal mantissas are flushed.
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == '1) && (ma == '0);
   assign b_inf  = (eb == '1) && (mb == '0);
   assign a_nan  = (ea == '1) && (ma != '0);
   assign b_nan  = (eb == '1) && (mb != '0);

   // Two guard bits above the fields keep both the carry-out (overflow) and a
   // negative biased exponent (underflow) visible in the sum.
`ifdef MITCHELL_CORR_EN
   logic [SW-1:0] corr;
   assign corr = ((ma != '0) && (mb != '0)) ? (SW'(1) << (MAN_W - 4)) : '0;
   assign sum  = {2'b00, ea, ma} + {2'b00, eb, mb} - BIAS_SH + corr;
`else
   assign sum  = {2'b00, ea, ma} + {2'b00, eb, mb} - BIAS_SH;
`endif

   assign sum_exp = signed'(sum[SW-1:MAN_W]);

   // Special operands take priority over the log-add path; only NaN and
   // saturation raise flags, inf/zero pass-through results are silent.
   always_comb begin
      result = '0;
      flags  = '0;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         result     = NAN_PAT;
         flags[NAN] = 1'b1;
      end else if (a_inf || b_inf) begin
         result = (FW+1)'(signed_inf(sign_r, EXP_W, MAN_W));
      end else if (a_zero || b_zero) begin
         result = {sign_r, {FW{1'b0}}};
      end else if (sum_exp >= EXP_MAX) begin
         result     = (FW+1)'(signed_inf(sign_r, EXP_W, MAN_W));
         flags[OVF] = 1'b1;
      end else if (sum_exp <= EXP_ZERO) begin
         result     = {sign_r, {FW{1'b0}}};
         flags[UDF] = 1'b1;
      end else begin
         result = {sign_r, sum[FW-1:0]};
      end
   end

endmodule

// File: rtl/lafpm_serial_mul.sv
// -----------------------------------------------------------------------------
// lafpm_serial_mul
// Serial-I/O wrapper around lafpm_core. Operands arrive least-significant beat
// first, one product is computed in a single COMPUTE cycle, and the result is
// streamed back out least-significant beat first. One product in flight.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : in  1      low freezes all state and masks both handshakes
//   in_valid   : in  1      operand beat valid
//   in_ready   : out 1      operand beat accepted on in_valid & in_ready
//   a_beat     : in  BUS_W  operand A slice
//   b_beat     : in  BUS_W  operand B slice (same beat index as a_beat)
//   out_valid  : out 1      result beat valid
//   out_ready  : in  1      result beat taken on out_valid & out_ready
//   out_beat   : out BUS_W  result slice, pad bits above the format are 0
//   out_flags  : out 3      {nan, overflow, underflow} of the last result
// Optional build macro MITCHELL_CORR_EN (handled inside lafpm_core).
// -----------------------------------------------------------------------------
module lafpm_serial_mul
   import lafpm_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int BUS_W = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BUS_W-1:0] a_beat,
   input  logic [BUS_W-1:0] b_beat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BUS_W-1:0] out_beat,
   output logic [2:0]       out_flags
);

   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int BEATS = beats_of(W, BUS_W);
   localparam int BW    = BEATS * BUS_W;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   lafpm_state_e  state, state_nxt;
   logic [CW-1:0] cnt;
   logic          armed;
   logic [BW-1:0] a_reg, b_reg, res_reg;
   logic [2:0]    flags_reg;
   logic [W-1:0]  core_res;
   logic [2:0]    core_flags;
   logic          in_fire, out_fire, last_beat;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign last_beat = (cnt == LAST);
   assign out_flags = flags_reg;

   lafpm_core #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_core (
      .a      (a_reg[W-1:0]),
      .b      (b_reg[W-1:0]),
      .result (core_res),
      .flags  (core_flags)
   );

   // State register; ena low holds the current state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD;
      end else if (ena) begin
         state <= state_nxt;
      end
   end

   // Next-state: the shared beat counter marks the last beat on both sides.
   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (in_fire && last_beat)  state_nxt = COMPUTE;
         COMPUTE: state_nxt = SEND;
         SEND:    if (out_fire && last_beat) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   // Outputs: 'armed' keeps in_ready low until the first edge after reset.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_beat  = '0;
      if (ena && state == LOAD) in_ready  = armed;
      if (ena && state == SEND) out_valid = 1'b1;
      if (state == SEND) out_beat = res_reg[cnt*BUS_W +: BUS_W];
   end

   // Datapath: beat capture, shared counter, and result/flag capture in
   // COMPUTE. Results are zero-extended so pad bits leave the block as 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed     <= 1'b0;
         cnt       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         flags_reg <= '0;
      end else if (ena) begin
         armed <= 1'b1;
         if (in_fire) begin
            a_reg[cnt*BUS_W +: BUS_W] <= a_beat;
            b_reg[cnt*BUS_W +: BUS_W] <= b_beat;
         end
         if (in_fire || out_fire) begin
            cnt <= last_beat ? '0 : cnt + 1'b1;
         end
         if (state == COMPUTE) begin
            res_reg   <= BW'(core_res);
            flags_reg <= core_flags;
         end
      end
   end

endmodule

// File: tb/tb_lafpm_serial_mul.sv
// -----------------------------------------------------------------------------
// tb_lafpm_serial_mul
// Self-checking bench: a half-precision instance driven from a vector table
// through a scoreboard queue, hand sequences for backpressure, enable gaps and
// mid-load reset, and a single-precision instance for the 4-beat case.
// -----------------------------------------------------------------------------
module tb_lafpm_serial_mul;

   logic       clk = 1'b0;
   logic       rst_n, ena, in_valid, out_ready;
   logic [7:0] a_beat, b_beat;
   logic       in_ready, out_valid;
   logic [7:0] out_beat;
   logic [2:0] out_flags;

   logic       sp_in_valid, sp_out_ready;
   logic [7:0] sp_a_beat, sp_b_beat;
   logic       sp_in_ready, sp_out_valid;
   logic [7:0] sp_out_beat;
   logic [2:0] sp_out_flags;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [2:0]  flags;
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic [2:0]  flags;
   } exp_t;

`ifdef MITCHELL_CORR_EN
   localparam logic [15:0] R_3E42 = 16'h4440;
   localparam logic [15:0] R_4141 = 16'h4640;
   localparam logic [31:0] R_SP   = 32'h4088_0000;
`else
   localparam logic [15:0] R_3E42 = 16'h4400;
   localparam logic [15:0] R_4141 = 16'h4600;
   localparam logic [31:0] R_SP   = 32'h4080_0000;
`endif

   exp_t sb_q[$];
   vec_t vecs[$];
   int   checks = 0;
   int   passes = 0;

   // Free-running 100 MHz clock shared by both instances.
   always #5 clk = ~clk;

   lafpm_serial_mul #(.EXP_W(5), .MAN_W(10), .BUS_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_beat    (a_beat),
      .b_beat    (b_beat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_beat  (out_beat),
      .out_flags (out_flags)
   );

   lafpm_serial_mul #(.EXP_W(8), .MAN_W(23), .BUS_W(8)) dut_sp (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .in_valid  (sp_in_valid),
      .in_ready  (sp_in_ready),
      .a_beat    (sp_a_beat),
      .b_beat    (sp_b_beat),
      .out_valid (sp_out_valid),
      .out_ready (sp_out_ready),
      .out_beat  (sp_out_beat),
      .out_flags (sp_out_flags)
   );

   // Hard stop in case a task's bounded waits are somehow bypassed.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 2 ms");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got === want) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
   endtask

   task automatic fail_now(input string name);
      checks++;
      $display("[TB] FAIL %s: got timeout, expected handshake", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive both beats of one product, optionally dropping ena for a few
   // cycles after the first beat while garbage sits on the bus.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] exp_res, input logic [2:0] exp_flags,
                                input int ena_gap, input string tag);
      int guard;
      exp_t e;
      e.res   = exp_res;
      e.flags = exp_flags;
      sb_q.push_back(e);
      for (int i = 0; i < 2; i++) begin
         a_beat   = a[i*8 +: 8];
         b_beat   = b[i*8 +: 8];
         in_valid = 1'b1;
         #1;
         guard = 0;
         while (!in_ready && guard < 40) begin
            tick();
            guard++;
         end
         if (!in_ready) begin
            fail_now({tag, "_in_ready_timeout"});
            in_valid = 1'b0;
            return;
         end
         tick();
         if (i == 0 && ena_gap > 0) begin
            ena    = 1'b0;
            a_beat = 8'hFF;
            b_beat = 8'hFF;
            #1;
            for (int k = 0; k < ena_gap; k++) begin
               check({tag, "_ena_low_in_ready"}, in_ready, 0);
               tick();
            end
            ena = 1'b1;
         end
      end
      in_valid = 1'b0;
      a_beat   = '0;
      b_beat   = '0;
   endtask

   // Called right after the accepting edge of the last input beat: checks
   // the one-cycle COMPUTE gap, optional stall stability, then drains beats.
   task automatic checkOutput(input int stall, input string tag);
      int          guard;
      exp_t        e;
      logic [15:0] got;
      got = '0;
      check({tag, "_latency_compute"}, out_valid, 0);
      tick();
      check({tag, "_latency_send"}, out_valid, 1);
      if (sb_q.size() == 0) begin
         fail_now({tag, "_scoreboard_empty"});
         return;
      end
      e = sb_q.pop_front();
      for (int s = 0; s < stall; s++) begin
         check({tag, "_stall_hold"}, {out_valid, out_beat, out_flags}, {1'b1, e.res[7:0], e.flags});
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         guard = 0;
         while (!out_valid && guard < 40) begin
            tick();
            guard++;
         end
         if (!out_valid) begin
            fail_now({tag, "_out_valid_timeout"});
            return;
         end
         check({tag, "_in_ready_send"}, in_ready, 0);
         check({tag, "_flags_beat"}, out_flags, e.flags);
         got[i*8 +: 8] = out_beat;
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
      check({tag, "_result"}, got, e.res);
      check({tag, "_back_to_load"}, {out_valid, in_ready}, 2'b01);
   endtask

   initial begin
      int          guard;
      logic [31:0] sp_a, sp_b, sp_got;

      vecs.push_back('{16'h3E00, 16'h4200, R_3E42,   3'b000});
      vecs.push_back('{16'h3C00, 16'hBC00, 16'hBC00, 3'b000});
      vecs.push_back('{16'h0000, 16'h3E00, 16'h0000, 3'b000});
      vecs.push_back('{16'h7800, 16'h7800, 16'h7C00, 3'b010});
      vecs.push_back('{16'h0400, 16'h3800, 16'h0000, 3'b001});
      vecs.push_back('{16'h7E00, 16'h3C00, 16'h7E00, 3'b100});
      vecs.push_back('{16'h7C00, 16'h0000, 16'h7E00, 3'b100});
      vecs.push_back('{16'h4100, 16'h4100, R_4141,   3'b000});
      vecs.push_back('{16'hC000, 16'hC200, 16'h4600, 3'b000});
      vecs.push_back('{16'hFC00, 16'h4000, 16'hFC00, 3'b000});
      vecs.push_back('{16'h8000, 16'h3C00, 16'h8000, 3'b000});
      vecs.push_back('{16'h0001, 16'h3C00, 16'h0000, 3'b000});
      vecs.push_back('{16'h0200, 16'h7C00, 16'h7E00, 3'b100});
      vecs.push_back('{16'h7800, 16'h4000, 16'h7C00, 3'b010});
      vecs.push_back('{16'h7800, 16'h3FFF, 16'h7BFF, 3'b000});
      vecs.push_back('{16'h8400, 16'h3800, 16'h8000, 3'b001});

      rst_n        = 1'b0;
      ena          = 1'b1;
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      a_beat       = '0;
      b_beat       = '0;
      sp_in_valid  = 1'b0;
      sp_out_ready = 1'b0;
      sp_a_beat    = '0;
      sp_b_beat    = '0;

      #2;
      check("reset_outputs", {in_ready, out_valid, out_beat, out_flags}, 0);
      check("reset_sp_outputs", {sp_in_ready, sp_out_valid, sp_out_beat, sp_out_flags}, 0);
      tick();
      tick();
      check("reset_held_in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1;
      check("release_in_ready_low", in_ready, 0);
      tick();
      check("first_edge_in_ready", in_ready, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags, 0, $sformatf("vec%0d", i));
         checkOutput(0, $sformatf("vec%0d", i));
      end

      applyStimulus(16'h3E00, 16'h4200, R_3E42, 3'b000, 0, "backpressure");
      checkOutput(5, "backpressure");

      applyStimulus(16'h3E00, 16'h4200, R_3E42, 3'b000, 3, "ena_gap");
      checkOutput(0, "ena_gap");

      // Leave nan set, then reset after one beat of a new load.
      applyStimulus(16'h7E00, 16'h3C00, 16'h7E00, 3'b100, 0, "pre_reset_nan");
      checkOutput(0, "pre_reset_nan");
      a_beat   = 8'h00;
      b_beat   = 8'h00;
      in_valid = 1'b1;
      #1;
      check("midload_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("midload_reset_outputs", {in_ready, out_valid, out_beat, out_flags}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      applyStimulus(16'h3E00, 16'h4200, R_3E42, 3'b000, 0, "after_reset");
      checkOutput(0, "after_reset");

      // Single-precision instance: four beats in, latency, four beats out.
      sp_a   = 32'h3FC0_0000;
      sp_b   = 32'h4040_0000;
      sp_got = '0;
      for (int i = 0; i < 4; i++) begin
         sp_a_beat   = sp_a[i*8 +: 8];
         sp_b_beat   = sp_b[i*8 +: 8];
         sp_in_valid = 1'b1;
         #1;
         guard = 0;
         while (!sp_in_ready && guard < 40) begin
            tick();
            guard++;
         end
         if (!sp_in_ready) fail_now("sp_in_ready_timeout");
         tick();
      end
      sp_in_valid = 1'b0;
      check("sp_latency_compute", sp_out_valid, 0);
      tick();
      check("sp_latency_send", sp_out_valid, 1);
      for (int i = 0; i < 4; i++) begin
         guard = 0;
         while (!sp_out_valid && guard < 40) begin
            tick();
            guard++;
         end
         if (!sp_out_valid) fail_now("sp_out_valid_timeout");
         check("sp_in_ready_send", sp_in_ready, 0);
         sp_got[i*8 +: 8] = sp_out_beat;
         sp_out_ready = 1'b1;
         tick();
         sp_out_ready = 1'b0;
      end
      check("sp_result", sp_got, R_SP);
      check("sp_flags", sp_out_flags, 3'b000);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
